// File: rtl/pc_jump_unit_pkg.sv
// rtl/pc_jump_unit_pkg.sv - opcode/func3 constants and opcode classification for pc_jump_unit
// Shared by the branch condition evaluator and the jump unit top.

package pc_jump_unit_pkg;

   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [1:0] {
      OP_OTHER  = 2'd0,
      OP_BRANCH = 2'd1,
      OP_JAL    = 2'd2,
      OP_JALR   = 2'd3
   } op_class_e;

   function automatic op_class_e classify_opcode(input logic [6:0] opc);
      op_class_e cls;
      case (opc)
         OPC_BRANCH: cls = OP_BRANCH;
         OPC_JAL:    cls = OP_JAL;
         OPC_JALR:   cls = OP_JALR;
         default:    cls = OP_OTHER;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/pc_jump_unit_branch_cond.sv
// rtl/pc_jump_unit_branch_cond.sv - branch condition from func3 and ALU compare flags
// Flags come from rs1-rs2; carry means borrow, i.e. rs1 <u rs2.

module pc_jump_unit_branch_cond
   import pc_jump_unit_pkg::*;
(
   input  logic [2:0] i_func3,
   input  logic       i_carry,
   input  logic       i_zero,
   input  logic       i_negative,
   input  logic       i_overflow,
   output logic       o_cond
);

   logic w_lt_signed;

   assign w_lt_signed = i_negative ^ i_overflow;

   always_comb begin
      o_cond = 1'b0;
      case (i_func3)
         F3_BEQ:  o_cond = i_zero;
         F3_BNE:  o_cond = ~i_zero;
         F3_BLT:  o_cond = w_lt_signed;
         F3_BGE:  o_cond = ~w_lt_signed;
         F3_BLTU: o_cond = i_carry;
         F3_BGEU: o_cond = ~i_carry;
         default: o_cond = 1'b0;
      endcase
   end

endmodule

// File: rtl/pc_jump_unit.sv
// rtl/pc_jump_unit.sv - execute-stage branch/JAL/JALR resolver with redirect counter
// Outputs other than redirect_count are combinational from the current inputs.

module pc_jump_unit
   import pc_jump_unit_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [XLEN-1:0]  pc,
   input  logic [XLEN-1:0]  immediate,
   input  logic [XLEN-1:0]  op1,
   input  logic [6:0]       opcode,
   input  logic [2:0]       func3,
   input  logic             carry_flag,
   input  logic             zero_flag,
   input  logic             negative_flag,
   input  logic             overflow_flag,
   input  logic             predictedTaken,
   output logic [XLEN-1:0]  jump_addr,
   output logic [XLEN-1:0]  update_pc,
   output logic             modify_pc,
   output logic             update_btb,
   output logic [CNT_W-1:0] redirect_count
);

   op_class_e       w_class;
   logic            w_cond;
   logic            w_taken;
   logic [XLEN-1:0] w_pc_rel;
   logic [XLEN-1:0] w_reg_rel;
   logic [XLEN-1:0] w_seq_pc;
   logic [CNT_W-1:0] r_redirect_count;

   assign w_class = classify_opcode(opcode);

   pc_jump_unit_branch_cond u_branch_cond (
      .i_func3    (func3),
      .i_carry    (carry_flag),
      .i_zero     (zero_flag),
      .i_negative (negative_flag),
      .i_overflow (overflow_flag),
      .o_cond     (w_cond)
   );

   assign w_pc_rel  = pc + immediate;
   assign w_reg_rel = op1 + immediate;
   assign w_seq_pc  = pc + XLEN'(4);

   always_comb begin
      w_taken    = 1'b0;
      modify_pc  = 1'b0;
      update_btb = 1'b0;
      jump_addr  = w_pc_rel;
      case (w_class)
         OP_BRANCH: begin
            w_taken    = w_cond;
            modify_pc  = w_cond ^ predictedTaken;
            update_btb = 1'b1;
         end
         OP_JAL: begin
            w_taken    = 1'b1;
            modify_pc  = ~predictedTaken;
            update_btb = 1'b1;
         end
         // No predicted target exists for JALR, so it always redirects.
         OP_JALR: begin
            w_taken    = 1'b1;
            modify_pc  = 1'b1;
            update_btb = 1'b1;
            jump_addr  = {w_reg_rel[XLEN-1:1], 1'b0};
         end
         default: begin
            w_taken    = 1'b0;
            modify_pc  = 1'b0;
            update_btb = 1'b0;
         end
      endcase
   end

   assign update_pc = w_taken ? jump_addr : w_seq_pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_redirect_count <= '0;
      end else if (modify_pc) begin
         r_redirect_count <= r_redirect_count + CNT_W'(1);
      end
   end

   assign redirect_count = r_redirect_count;

endmodule

// File: tb/tb_pc_jump_unit.sv
// tb/tb_pc_jump_unit.sv - self-checking bench for pc_jump_unit
// Directed table, reset/counter sequences, then random compares against a reference model.

module tb_pc_jump_unit;

   localparam logic [6:0] B_BR   = 7'b1100011;
   localparam logic [6:0] B_JAL  = 7'b1101111;
   localparam logic [6:0] B_JALR = 7'b1100111;
   localparam logic [6:0] B_ALU  = 7'b0110011;

   logic        clk;
   logic        rst;
   logic [31:0] pc, immediate, op1;
   logic [6:0]  opcode;
   logic [2:0]  func3;
   logic        carry_flag, zero_flag, negative_flag, overflow_flag;
   logic        predictedTaken;
   logic [31:0] jump_addr, update_pc;
   logic        modify_pc, update_btb;
   logic [15:0] redirect_count;

   pc_jump_unit #(.XLEN(32), .CNT_W(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .pc             (pc),
      .immediate      (immediate),
      .op1            (op1),
      .opcode         (opcode),
      .func3          (func3),
      .carry_flag     (carry_flag),
      .zero_flag      (zero_flag),
      .negative_flag  (negative_flag),
      .overflow_flag  (overflow_flag),
      .predictedTaken (predictedTaken),
      .jump_addr      (jump_addr),
      .update_pc      (update_pc),
      .modify_pc      (modify_pc),
      .update_btb     (update_btb),
      .redirect_count (redirect_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Expected redirect count: tracks the modify_pc the bench expects for the applied inputs.
   logic        exp_mod_now = 1'b0;
   logic [15:0] m_cnt = 16'd0;
   always @(posedge clk) begin
      if (rst) m_cnt = 16'd0;
      else if (exp_mod_now) m_cnt = m_cnt + 16'd1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic [3:0]  czn_v;
      logic        pred;
      logic [31:0] pc_v;
      logic [31:0] imm_v;
      logic [31:0] op1_v;
      logic [31:0] e_jump;
      logic [31:0] e_upc;
      logic        e_mod;
      logic        e_btb;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic [6:0] o, input logic [2:0] f, input logic [3:0] fl,
                               input logic p, input logic [31:0] pcv, input logic [31:0] op1v,
                               input logic [31:0] ej, input logic [31:0] eu,
                               input logic em, input logic eb);
      vec_t v;
      v.opc = o; v.f3 = f; v.czn_v = fl; v.pred = p; v.pc_v = pcv; v.imm_v = 32'h10;
      v.op1_v = op1v; v.e_jump = ej; v.e_upc = eu; v.e_mod = em; v.e_btb = eb;
      return v;
   endfunction

   task automatic drive(input logic [6:0] o, input logic [2:0] f, input logic [3:0] fl,
                        input logic p, input logic [31:0] pcv, input logic [31:0] imv,
                        input logic [31:0] op1v);
      opcode = o; func3 = f;
      {carry_flag, zero_flag, negative_flag, overflow_flag} = fl;
      predictedTaken = p; pc = pcv; immediate = imv; op1 = op1v;
   endtask

   // Reference: decide from operand values, not from flags.
   task automatic ref_model(input logic [6:0] o, input logic [2:0] f, input logic [31:0] a,
                            input logic [31:0] b, input logic p, input logic [31:0] pcv,
                            input logic [31:0] imv, input logic [31:0] op1v,
                            output logic [31:0] ej, output logic [31:0] eu,
                            output logic em, output logic eb);
      bit taken;
      bit cond;
      case (f)
         3'b000: cond = (a == b);
         3'b001: cond = (a != b);
         3'b100: cond = ($signed(a) <  $signed(b));
         3'b101: cond = ($signed(a) >= $signed(b));
         3'b110: cond = (a <  b);
         3'b111: cond = (a >= b);
         default: cond = 0;
      endcase
      if (o == B_JALR) ej = (op1v + imv) & 32'hFFFF_FFFE;
      else             ej = pcv + imv;
      taken = (o == B_BR) ? cond : (o == B_JAL || o == B_JALR);
      eu = taken ? ej : pcv + 32'd4;
      if (o == B_BR)        em = cond ^ p;
      else if (o == B_JAL)  em = !p;
      else if (o == B_JALR) em = 1'b1;
      else                  em = 1'b0;
      eb = (o == B_BR || o == B_JAL || o == B_JALR);
   endtask

   initial begin
      // {C,Z,N,V}
      vecs.push_back(mk(B_BR,   3'b000, 4'b0100, 0, 32'h1000, 0, 32'h1010, 32'h1010, 1, 1));
      vecs.push_back(mk(B_BR,   3'b000, 4'b0000, 0, 32'h1000, 0, 32'h1010, 32'h1004, 0, 1));
      vecs.push_back(mk(B_BR,   3'b100, 4'b0010, 0, 32'h1000, 0, 32'h1010, 32'h1010, 1, 1));
      vecs.push_back(mk(B_BR,   3'b101, 4'b0000, 0, 32'h1000, 0, 32'h1010, 32'h1010, 1, 1));
      vecs.push_back(mk(B_BR,   3'b110, 4'b1000, 0, 32'h1000, 0, 32'h1010, 32'h1010, 1, 1));
      vecs.push_back(mk(B_BR,   3'b111, 4'b0000, 0, 32'h1000, 0, 32'h1010, 32'h1010, 1, 1));
      vecs.push_back(mk(B_BR,   3'b100, 4'b0011, 0, 32'h1000, 0, 32'h1010, 32'h1004, 0, 1));
      vecs.push_back(mk(B_BR,   3'b000, 4'b0100, 1, 32'h1000, 0, 32'h1010, 32'h1010, 0, 1));
      vecs.push_back(mk(B_BR,   3'b000, 4'b0000, 1, 32'h1000, 0, 32'h1010, 32'h1004, 1, 1));
      vecs.push_back(mk(B_BR,   3'b001, 4'b0000, 0, 32'h1000, 0, 32'h1010, 32'h1010, 1, 1));
      vecs.push_back(mk(B_BR,   3'b010, 4'b1111, 0, 32'h1000, 0, 32'h1010, 32'h1004, 0, 1));
      vecs.push_back(mk(B_BR,   3'b011, 4'b1111, 1, 32'h1000, 0, 32'h1010, 32'h1004, 1, 1));
      vecs.push_back(mk(B_JAL,  3'b000, 4'b0000, 0, 32'h1000, 0, 32'h1010, 32'h1010, 1, 1));
      vecs.push_back(mk(B_JAL,  3'b110, 4'b1111, 1, 32'h1000, 0, 32'h1010, 32'h1010, 0, 1));
      vecs.push_back(mk(B_JALR, 3'b000, 4'b0000, 0, 32'h1000, 32'h3003, 32'h3012, 32'h3012, 1, 1));
      vecs.push_back(mk(B_JALR, 3'b000, 4'b0000, 1, 32'h1000, 32'h3003, 32'h3012, 32'h3012, 1, 1));
      vecs.push_back(mk(B_ALU,  3'b000, 4'b0100, 1, 32'h1000, 0, 32'h1010, 32'h1004, 0, 0));
      vecs.push_back(mk(B_BR,   3'b000, 4'b0000, 0, 32'hFFFF_FFFC, 0, 32'h0000_000C, 32'h0000_0000, 0, 1));

      // Reset state
      rst = 1'b1;
      drive(B_ALU, 3'b000, 4'b0000, 0, 32'h1000, 32'h10, 0);
      exp_mod_now = 1'b0;
      @(posedge clk); #1;
      check("reset_count", {16'd0, redirect_count}, 32'd0);

      // Three redirect cycles, then reset has priority while redirect continues
      @(negedge clk);
      rst = 1'b0;
      drive(B_JALR, 3'b000, 4'b0000, 0, 32'h1000, 32'h10, 32'h3003);
      exp_mod_now = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      check("count_after_3", {16'd0, redirect_count}, 32'd3);
      rst = 1'b1;
      @(posedge clk); #1;
      check("count_reset_mid", {16'd0, redirect_count}, 32'd0);
      check("jalr_during_rst", update_pc, 32'h3012);
      @(negedge clk);
      rst = 1'b0;

      // Directed table
      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].opc, vecs[i].f3, vecs[i].czn_v, vecs[i].pred,
               vecs[i].pc_v, vecs[i].imm_v, vecs[i].op1_v);
         exp_mod_now = vecs[i].e_mod;
         #1;
         check($sformatf("vec%0d_jump", i), jump_addr, vecs[i].e_jump);
         check($sformatf("vec%0d_upc", i), update_pc, vecs[i].e_upc);
         check($sformatf("vec%0d_mod", i), {31'd0, modify_pc}, {31'd0, vecs[i].e_mod});
         check($sformatf("vec%0d_btb", i), {31'd0, update_btb}, {31'd0, vecs[i].e_btb});
         check($sformatf("vec%0d_cnt", i), {16'd0, redirect_count}, {16'd0, m_cnt});
      end

      // Random against reference model
      for (int k = 0; k < 400; k++) begin
         logic [31:0] a, b, d, pcv, imv, op1v, ej, eu;
         logic [6:0]  o;
         logic [2:0]  f;
         logic        p, em, eb, c, z, n, v;
         int          sel;
         a = $urandom; b = ($urandom_range(0, 3) == 0) ? a : $urandom;
         if ($urandom_range(0, 3) == 0) b = a ^ 32'h8000_0000;
         d = a - b;
         c = (a < b); z = (d == 0); n = d[31];
         v = (a[31] != b[31]) && (d[31] != a[31]);
         sel = $urandom_range(0, 5);
         o = (sel < 3) ? B_BR : (sel == 3) ? B_JAL : (sel == 4) ? B_JALR : 7'($urandom);
         f = 3'($urandom); p = 1'($urandom);
         pcv = $urandom; imv = $urandom; op1v = $urandom;
         if (o != B_BR) {c, z, n, v} = 4'($urandom);
         ref_model(o, f, a, b, p, pcv, imv, op1v, ej, eu, em, eb);
         @(negedge clk);
         rst = ($urandom_range(0, 19) == 0);
         drive(o, f, {c, z, n, v}, p, pcv, imv, op1v);
         exp_mod_now = em;
         #1;
         check("rnd_jump", jump_addr, ej);
         check("rnd_upc", update_pc, eu);
         check("rnd_mod", {31'd0, modify_pc}, {31'd0, em});
         check("rnd_btb", {31'd0, update_btb}, {31'd0, eb});
         check("rnd_cnt", {16'd0, redirect_count}, {16'd0, m_cnt});
      end

      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check("final_cnt", {16'd0, redirect_count}, {16'd0, m_cnt});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
